// File: rtl/codec_mixer_if.sv
// Bus between the voice sources / codec frame timing and the codec_mixer.
//
// Strobe semantics: every *_valid / new_frame line is a one-cycle, valid-only
// strobe with no ready and no backpressure. The producer asserts it for exactly
// one clk cycle together with its data; the consumer must accept it that cycle.
// mix_valid is the same kind of strobe in the other direction, and mix_out
// stays stable between mix_valid pulses.
interface codec_mixer_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 4,
  parameter int OUT_W    = 24
);
  logic [NUM_CH*SAMPLE_W-1:0] ch_sample;
  logic [NUM_CH-1:0]          ch_valid;
  logic [NUM_CH*GAIN_W-1:0]   ch_gain;
  logic [NUM_CH-1:0]          ch_mute;
  logic                       new_frame;
  logic [OUT_W-1:0]           mix_out;
  logic                       mix_valid;
  logic                       busy;
  logic                       clip;
  logic [7:0]                 drop_count;
  logic [1:0]                 dbg_state;

  // Source / frame-timing side.
  modport master (
    output ch_sample, ch_valid, ch_gain, ch_mute, new_frame,
    input  mix_out, mix_valid, busy, clip, drop_count, dbg_state
  );

  // Mixer side.
  modport slave (
    input  ch_sample, ch_valid, ch_gain, ch_mute, new_frame,
    output mix_out, mix_valid, busy, clip, drop_count, dbg_state
  );
endinterface

// File: rtl/codec_mixer.sv
// N-voice sample mixer feeding the codec headphone word. Each voice's latest
// sample is held; on a codec frame strobe all voices are snapshotted, scaled
// by gain (unity = 2**(GAIN_W-1)), summed one channel per cycle, saturated to
// SAMPLE_W and presented MSB-aligned in an OUT_W word.
module codec_mixer #(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 16,
  parameter int GAIN_W     = 4,
  parameter int OUT_W      = 24,
  parameter int HOLD_STALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  codec_mixer_if.slave bus
);

  localparam int CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state;
  logic [SAMPLE_W-1:0]        hold      [NUM_CH];
  logic [NUM_CH-1:0]          fresh;
  logic signed [SAMPLE_W-1:0] snap      [NUM_CH];
  logic signed [SAMPLE_W-1:0] snap_next [NUM_CH];
  logic [GAIN_W-1:0]          gain_q    [NUM_CH];
  logic signed [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]           idx;
  logic                       pending;
  logic                       start;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   term;
  logic [SAMPLE_W-1:0]        sat_val;
  logic                       sat_hit;
  logic [OUT_W-1:0]           sat_word;

  // A mix starts from IDLE, or back-to-back from DONE, when a frame is waiting.
  // A frame arriving in DONE is served by that same DONE->ACC transition.
  always_comb begin
    start = 1'b0;
    if ((state == IDLE) || (state == DONE)) begin
      start = bus.new_frame | pending;
    end
  end

  // Per-voice holding registers track every strobe regardless of FSM state.
  // A strobe in the snapshot cycle is bypassed into the snapshot, so it is
  // consumed and its fresh flag clears along with the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
      fresh <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.ch_valid[k]) hold[k] <= bus.ch_sample[k*SAMPLE_W +: SAMPLE_W];
      end
      if (start) fresh <= '0;
      else       fresh <= fresh | bus.ch_valid;
    end
  end

  // Snapshot value per voice: mute wins, then same-cycle bypass, then held.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.ch_mute[k]) begin
        snap_next[k] = '0;
      end else if (bus.ch_valid[k]) begin
        snap_next[k] = $signed(bus.ch_sample[k*SAMPLE_W +: SAMPLE_W]);
      end else if ((HOLD_STALE != 0) || fresh[k]) begin
        snap_next[k] = $signed(hold[k]);
      end else begin
        snap_next[k] = '0;
      end
    end
  end

  // Scaled contribution of the channel selected by idx; >>> floors negatives.
  always_comb begin
    prod = PROD_W'(snap[idx]) * PROD_W'($signed({1'b0, gain_q[idx]}));
    term = prod >>> (GAIN_W - 1);
  end

  // Clamp the accumulator to the signed SAMPLE_W range and MSB-align it.
  always_comb begin
    sat_hit = 1'b1;
    if (acc > SAT_MAX) begin
      sat_val = SAT_MAX[SAMPLE_W-1:0];
    end else if (acc < SAT_MIN) begin
      sat_val = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      sat_val = acc[SAMPLE_W-1:0];
      sat_hit = 1'b0;
    end
    sat_word = '0;
    sat_word[OUT_W-1 -: SAMPLE_W] = sat_val;
  end

  // Mix sequencer: snapshot, accumulate NUM_CH cycles, publish, with a
  // one-deep pending slot for frames that arrive while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pending        <= 1'b0;
      acc            <= '0;
      idx            <= '0;
      bus.mix_out    <= '0;
      bus.mix_valid  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.clip       <= 1'b0;
      bus.drop_count <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        snap[k]   <= '0;
        gain_q[k] <= '0;
      end
    end else begin
      bus.mix_valid <= 1'b0;
      if (start) begin
        for (int k = 0; k < NUM_CH; k++) begin
          snap[k]   <= snap_next[k];
          gain_q[k] <= bus.ch_gain[k*GAIN_W +: GAIN_W];
        end
        acc      <= '0;
        idx      <= '0;
        state    <= ACC;
        bus.busy <= 1'b1;
        // The slot is consumed; a frame in this same cycle refills it only
        // when it was the slot (not the new frame) that triggered the start.
        pending  <= pending & bus.new_frame;
      end
      case (state)
        IDLE: begin
        end
        ACC: begin
          acc <= acc + ACC_W'(term);
          if (idx == CNT_W'(NUM_CH - 1)) state <= DONE;
          else                           idx   <= idx + 1'b1;
          if (bus.new_frame) begin
            if (!pending)                      pending        <= 1'b1;
            else if (bus.drop_count != 8'hFF)  bus.drop_count <= bus.drop_count + 8'd1;
          end
        end
        DONE: begin
          bus.mix_out   <= sat_word;
          bus.clip      <= sat_hit;
          bus.mix_valid <= 1'b1;
          if (!start) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dbg_state = state;

endmodule

// File: tb/tb_codec_mixer.sv
// Directed bench for codec_mixer (4 voices, 16-bit samples, 4-bit gain, 24-bit word).
module tb_codec_mixer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  codec_mixer_if #(.NUM_CH(4), .SAMPLE_W(16), .GAIN_W(4), .OUT_W(24)) bus ();

  codec_mixer #(
    .NUM_CH(4), .SAMPLE_W(16), .GAIN_W(4), .OUT_W(24), .HOLD_STALE(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers: all start and end at #1 after a rising edge.
  task automatic set_voices(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] s3);
    bus.ch_sample = {s3, s2, s1, s0};
    bus.ch_valid  = 4'hF;
    @(posedge clk); #1;
    bus.ch_valid  = 4'h0;
  endtask

  // Pulse new_frame (optionally with same-cycle voice strobes) and check
  // latency, result word, clip and one-cycle pulse width.
  task automatic run_frame(input string tag, input logic [3:0] byp,
                           input logic [23:0] exp_out, input logic exp_clip);
    int lat;
    bus.new_frame = 1'b1;
    bus.ch_valid  = byp;
    @(posedge clk); #1;
    bus.new_frame = 1'b0;
    bus.ch_valid  = 4'h0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.mix_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"},  lat, 5);
    check({tag, "_out"},  bus.mix_out, exp_out);
    check({tag, "_clip"}, bus.clip, exp_clip);
    @(posedge clk); #1;
    check({tag, "_pulse"}, bus.mix_valid, 1'b0);
    check({tag, "_held"},  bus.mix_out, exp_out);
  endtask

  initial begin
    int t1, t2, np, nv;
    n_vec  = 0;
    n_miss = 0;
    bus.ch_sample = '0;
    bus.ch_valid  = '0;
    bus.ch_gain   = {4'd8, 4'd8, 4'd8, 4'd8};
    bus.ch_mute   = '0;
    bus.new_frame = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1. Reset state, then a frame with nothing ever strobed.
    check("rst_out",   bus.mix_out, 24'h0);
    check("rst_valid", bus.mix_valid, 1'b0);
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_clip",  bus.clip, 1'b0);
    check("rst_drop",  bus.drop_count, 8'd0);
    check("rst_state", bus.dbg_state, 2'd0);
    run_frame("empty", 4'h0, 24'h000000, 1'b0);

    // 2. Plain unity-gain sum: 1000+2000-500+0 = 2500.
    set_voices(16'd1000, 16'd2000, -16'sd500, 16'd0);
    run_frame("sum", 4'h0, 24'h09C400, 1'b0);

    // 3. Saturation both ways.
    set_voices(16'h7000, 16'h7000, 16'h7000, 16'h7000);
    run_frame("sat_pos", 4'h0, 24'h7FFF00, 1'b1);
    set_voices(-16'sh7000, -16'sh7000, -16'sh7000, -16'sh7000);
    run_frame("sat_neg", 4'h0, 24'h800000, 1'b1);

    // 4. Half gain on ch0, stale hold, floor of negatives, mute, bypass.
    bus.ch_gain = {4'd8, 4'd8, 4'd8, 4'd4};
    set_voices(16'd1001, 16'd0, 16'd0, 16'd0);
    run_frame("half", 4'h0, 24'h01F400, 1'b0);
    run_frame("stale", 4'h0, 24'h01F400, 1'b0);
    set_voices(-16'sd1001, 16'd0, 16'd0, 16'd0);
    run_frame("half_neg", 4'h0, 24'hFE0B00, 1'b0);
    bus.ch_mute = 4'b0001;
    run_frame("mute", 4'h0, 24'h000000, 1'b0);
    bus.ch_mute = 4'b0000;
    bus.ch_gain = {4'd8, 4'd8, 4'd8, 4'd8};
    bus.ch_sample[15:0] = 16'd3000;
    run_frame("bypass", 4'b0001, 24'h0BB800, 1'b0);

    // 5. Three back-to-back frames: one served, one pending, one dropped.
    bus.new_frame = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.new_frame = 1'b0;
    np = 0; t1 = 0; t2 = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.mix_valid) begin
        np++;
        if (np == 1) t1 = c;
        else         t2 = c;
      end
    end
    check("burst_pulses", np, 2);
    check("burst_gap",    t2 - t1, 5);
    check("burst_drop",   bus.drop_count, 8'd1);

    // Continuous frames pile up drops until the counter saturates.
    bus.new_frame = 1'b1;
    repeat (600) @(posedge clk);
    #1 bus.new_frame = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("drop_sat",  bus.drop_count, 8'd255);
    check("drain_busy", bus.busy, 1'b0);

    // 6. Abort during ACC after a clipping mix.
    set_voices(16'h7000, 16'h7000, 16'h7000, 16'h7000);
    run_frame("pre_abort", 4'h0, 24'h7FFF00, 1'b1);
    bus.new_frame = 1'b1;
    @(posedge clk); #1;
    bus.new_frame = 1'b0;
    @(posedge clk); #1;
    check("acc_state", bus.dbg_state, 2'd1);
    check("acc_busy",  bus.busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_out",   bus.mix_out, 24'h0);
    check("abort_clip",  bus.clip, 1'b0);
    check("abort_busy",  bus.busy, 1'b0);
    check("abort_drop",  bus.drop_count, 8'd0);
    check("abort_state", bus.dbg_state, 2'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.mix_valid) nv++;
    end
    check("abort_novalid", nv, 0);
    set_voices(16'd100, 16'd200, 16'd300, 16'd400);
    run_frame("recover", 4'h0, 24'h03E800, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
